irq_pending_encoder: RTL

//  Front end of the 4-line request path, upstream of the 4:2 encoders.

---
 rtl/irq_pending_encoder.sv | 99 +++++++++
 1 files changed

// File: rtl/irq_pending_encoder.sv
// Sticky pending/overflow capture for four request lines, with a masked
// priority pick (bit 3 highest) held on a valid/ack handshake until accepted.
module irq_pending_encoder #(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] irq_in,
  input  logic [3:0] mask,
  input  logic       irq_ack,
  input  logic [3:0] ovf_clr,
  output logic       irq_valid,
  output logic [1:0] irq_id,
  output logic [3:0] pending,
  output logic [3:0] overflow
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] irq_d;
  logic [3:0] ev;
  logic [3:0] clr;
  logic [3:0] eligible;
  logic [3:0] pending_nxt;
  logic [3:0] overflow_nxt;
  logic       irq_valid_nxt;
  logic [1:0] irq_id_nxt;

  function automatic logic [1:0] highest(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[3])      idx = 2'd3;
    else if (v[2]) idx = 2'd2;
    else if (v[1]) idx = 2'd1;
    return idx;
  endfunction

  // A new event on a line is set-dominant over the ack clearing that same line.
  always_comb begin
    ev = EDGE_MODE ? (irq_in & ~irq_d) : irq_in;
    clr = 4'b0000;
    if (irq_valid && irq_ack) clr[irq_id] = 1'b1;
    pending_nxt  = ev | (pending & ~clr);
    overflow_nxt = overflow & ~ovf_clr;
    if (EDGE_MODE) overflow_nxt = overflow_nxt | (ev & pending & ~clr);
    eligible = pending & ~mask;
  end

  always_comb begin
    state_nxt     = state;
    irq_valid_nxt = irq_valid;
    irq_id_nxt    = irq_id;
    unique case (state)
      IDLE: begin
        irq_valid_nxt = 1'b0;
        if (eligible != 4'b0000) begin
          irq_id_nxt    = highest(eligible);
          irq_valid_nxt = 1'b1;
          state_nxt     = PRESENT;
        end
      end
      PRESENT: begin
        // The presented index stays frozen regardless of new events or mask edits.
        irq_valid_nxt = 1'b1;
        if (irq_ack) begin
          irq_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: begin
        irq_valid_nxt = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_id    <= 2'd0;
      pending   <= 4'b0000;
      overflow  <= 4'b0000;
      irq_d     <= 4'b0000;
    end else begin
      state     <= state_nxt;
      irq_valid <= irq_valid_nxt;
      irq_id    <= irq_id_nxt;
      pending   <= pending_nxt;
      overflow  <= overflow_nxt;
      irq_d     <= irq_in;
    end
  end

endmodule
